mem2_rr_arbiter: RTL and testbench
==================================

// Module: mem2_rr_arbiter
// PURPOSE
//  Two-port round-robin arbiter sharing one single-port on-chip RAM (32-bit, byteenable,
//  registered address, unregistered q) between two Avalon-MM masters (mN_ below, N=0,1).
//  Sits between the masters and the RAM slave. Grants at most one access per cycle,
//  returns read data with fixed 1-cycle latency and bounds each master's wait to 1 cycle.
//  Accesses at or above DEPTH are blocked.
// PARAMETERS
//  ADDR_W   15     word-address width
//  DATA_W   32     data width
//  BE_W     4      byteenable width (DATA_W/8)
//  DEPTH    23552  number of implemented words; addresses >= DEPTH are out-of-range
// PORTS
//  clk                 in   1       single clock, all logic rising-edge
//  reset_n             in   1       asynchronous, active-low reset
//  mN_address          in   ADDR_W  master N word address
//  mN_byteenable       in   BE_W    master N byte lanes (write only)
//  mN_read             in   1       master N read request
//  mN_write            in   1       master N write request
//  mN_writedata        in   DATA_W  master N write data
//  mN_waitrequest      out  1       1 = command not accepted this cycle
//  mN_readdata         out  DATA_W  read data, valid when mN_readdatavalid=1
//  mN_readdatavalid    out  1       one-cycle pulse per accepted read
//  mem_address         out  ADDR_W  to RAM address
//  mem_byteenable      out  BE_W    to RAM byteenable
//  mem_chipselect      out  1       to RAM chipselect
//  mem_write           out  1       to RAM write
//  mem_writedata       out  DATA_W  to RAM writedata
//  mem_clken           out  1       to RAM clken; 1 whenever reset_n=1
//  mem_readdata        in   DATA_W  from RAM readdata (valid cycle after address)
//  err_clr             in   1       synchronous clear of oor_err
//  oor_err             out  1       sticky: an out-of-range access was accepted
// BEHAVIOUR
//  - Reset (reset_n=0, async): mN_waitrequest=1, mN_readdatavalid=0, mN_readdata=0,
//    mem_chipselect=0, mem_write=0, mem_clken=0, oor_err=0, last_grant=1 (m0 wins first tie).
//    Pending read returns are discarded; no readdatavalid follows a reset.
//  - reqN = mN_read | mN_write. read&write together is treated as a write (no data return).
//  - Grant (combinational, same cycle): only one req -> that master; both -> master
//    != last_grant; none -> no grant. last_grant <= winner at each granted edge.
//  - Winner: mN_waitrequest=0, its command is muxed to mem_*; mem_chipselect=1.
//    Loser and idle masters: waitrequest=1. Mux holds last winner when idle, chipselect=0.
//  - Read latency: granted in cycle T -> mN_readdatavalid=1 in T+1 only (registered owner
//    flag), mN_readdata=mem_readdata in T+1, else 0. Back-to-back reads: 1 per cycle.
//  - Write: committed at edge ending grant cycle; byte lanes per mN_byteenable.
//  - Out-of-range (address >= DEPTH): access is granted (waitrequest=0) but
//    mem_chipselect=0, mem_write=0; read returns 0x00000000 with normal T+1 readdatavalid;
//    oor_err<=1. err_clr clears oor_err; simultaneous new OOR access wins (stays 1).
//  - Fairness: with both requesting continuously grants strictly alternate; max wait 1 cycle.
//  - Masters may change requests when waitrequest=1; arbiter holds no command state.
// TESTING
//  1. m0 write 0xDEADBEEF @0x0010 be=0xF, then m0 read @0x0010 -> m0_readdatavalid in
//     cycle after grant, m0_readdata=0xDEADBEEF, m1_readdatavalid=0 throughout.
//  2. After reset both read continuously 6 cycles -> grants m0,m1,m0,m1,m0,m1; each gets
//     3 readdatavalid pulses, each 1 cycle after its grant; waitrequest never 1 for >1 cycle.
//  3. Word 0x0 = 0x00000000; m1 write 0x11223344 be=0x5 -> m0 read 0x0 returns 0x00220044.
//  4. m0 read @23552 -> readdata=0, readdatavalid=1, oor_err=1, mem_chipselect=0;
//     m1 write @0x7FFF -> RAM unchanged; err_clr pulse -> oor_err=0.
//  5. reset_n low in cycle after m1 read grant -> no m1_readdatavalid, all outputs at reset
//     values; after release both request -> m0 granted first.
//  6. m1 alone writes 4 consecutive cycles, m0 idle -> m1_waitrequest=0 every cycle,
//     4 RAM writes, m0_waitrequest=1.

Source files
------------

// File: rtl/mem2_rr_arbiter_if.sv
// mem2_rr_arbiter_if: Avalon-MM bus of one master (address/byteenable/read/write/writedata in, waitrequest/readdata/readdatavalid back)
interface mem2_rr_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int BE_W = 4
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0] byteenable;
  logic read;
  logic write;
  logic [DATA_W-1:0] writedata;
  logic waitrequest;
  logic [DATA_W-1:0] readdata;
  logic readdatavalid;
  modport master(
    output address, byteenable, read, write, writedata,
    input waitrequest, readdata, readdatavalid
  );
  modport slave(
    input address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/mem2_rr_arbiter.sv
// mem2_rr_arbiter: round-robin sharing of one single-port RAM by two Avalon-MM masters (m0/m1 slave buses in, mem_* RAM port out, err_clr/oor_err sticky out-of-range flag)
module mem2_rr_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int BE_W = 4,
  parameter int DEPTH = 23552
) (
  input  logic clk,
  input  logic reset_n,
  mem2_rr_arbiter_if.slave m0,
  mem2_rr_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0] mem_byteenable,
  output logic mem_chipselect,
  output logic mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic err_clr,
  output logic oor_err
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  logic req0, req1, g0, g1, gnt, sel, wr, rd, in_rng;
  logic last_grant, rv0_q, rv1_q, oor_q;
  always_comb begin
    req0 = m0.read | m0.write;
    req1 = m1.read | m1.write;
    g0 = reset_n & req0 & (~req1 | last_grant);
    g1 = reset_n & req1 & (~req0 | ~last_grant);
    gnt = g0 | g1;
    sel = g1 | (~g0 & last_grant);
    mem_address = sel ? m1.address : m0.address;
    mem_byteenable = sel ? m1.byteenable : m0.byteenable;
    mem_writedata = sel ? m1.writedata : m0.writedata;
    wr = sel ? m1.write : m0.write;
    rd = (sel ? m1.read : m0.read) & ~wr;
    in_rng = {1'b0, mem_address} < LIMIT;
    mem_chipselect = gnt & in_rng;
    mem_write = mem_chipselect & wr;
    mem_clken = reset_n;
    m0.waitrequest = ~g0;
    m1.waitrequest = ~g1;
    m0.readdatavalid = rv0_q;
    m1.readdatavalid = rv1_q;
    m0.readdata = (rv0_q & ~oor_q) ? mem_readdata : '0;
    m1.readdata = (rv1_q & ~oor_q) ? mem_readdata : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      oor_q <= 1'b0;
      oor_err <= 1'b0;
    end else begin
      last_grant <= gnt ? g1 : last_grant;
      rv0_q <= g0 & rd;
      rv1_q <= g1 & rd;
      oor_q <= ~in_rng;
      oor_err <= (gnt & ~in_rng) | (oor_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_mem2_rr_arbiter.sv
// tb_mem2_rr_arbiter: directed and random check of mem2_rr_arbiter against a transaction-level model
module tb_mem2_rr_arbiter;
  localparam int AW = 15, DW = 32, BW = 4, DEPTH = 23552;
  typedef struct packed {
    logic r;
    logic w;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] d;
  } cmd_t;
  localparam cmd_t IDLE = '0;
  logic clk = 1'b0, reset_n = 1'b0, err_clr = 1'b0;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic mem_chipselect, mem_write, mem_clken, oor_err;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] mdl [DEPTH];
  logic [AW-1:0] ram_a = '0;
  int total = 0, bad = 0, ram_wr = 0, cnt0 = 0, cnt1 = 0, last = 1, n;
  logic e_rv0, e_rv1, e_err;
  logic [DW-1:0] e_rd;
  mem2_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m0 ();
  mem2_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) m1 ();
  mem2_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .m0(m0),
    .m1(m1),
    .mem_address(mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_clken(mem_clken),
    .mem_readdata(mem_readdata),
    .err_clr(err_clr),
    .oor_err(oor_err)
  );
  always #5 clk = ~clk;
  assign mem_readdata = ram[ram_a];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      ram_a <= mem_address;
      if (mem_write) begin
        ram_wr <= ram_wr + 1;
        for (int i = 0; i < BW; i++)
          if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
      end
    end
  end
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic cmd_t rdc(input int a);
    return '{r: 1'b1, w: 1'b0, a: AW'(a), be: '0, d: '0};
  endfunction
  function automatic cmd_t wrc(input int a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    return '{r: 1'b0, w: 1'b1, a: AW'(a), be: be, d: d};
  endfunction
  function automatic cmd_t rnd();
    cmd_t c;
    c.r = 1'($urandom);
    c.w = 1'($urandom);
    case ($urandom % 8)
      0: c.a = AW'(DEPTH - 1);
      1: c.a = AW'(DEPTH);
      2: c.a = AW'($urandom);
      default: c.a = AW'($urandom % 16);
    endcase
    c.be = BW'($urandom);
    c.d = $urandom;
    return c;
  endfunction
  task automatic drive(input cmd_t c0, input cmd_t c1, input logic clr);
    m0.read = c0.r;
    m0.write = c0.w;
    m0.address = c0.a;
    m0.byteenable = c0.be;
    m0.writedata = c0.d;
    m1.read = c1.r;
    m1.write = c1.w;
    m1.address = c1.a;
    m1.byteenable = c1.be;
    m1.writedata = c1.d;
    err_clr = clr;
  endtask
  task automatic model_reset();
    last = 1;
    e_rv0 = 1'b0;
    e_rv1 = 1'b0;
    e_err = 1'b0;
  endtask
  task automatic chk_rst(input string t);
    chk({t, "_wait0"}, m0.waitrequest, 1'b1);
    chk({t, "_wait1"}, m1.waitrequest, 1'b1);
    chk({t, "_rv0"}, m0.readdatavalid, 1'b0);
    chk({t, "_rv1"}, m1.readdatavalid, 1'b0);
    chk({t, "_rd0"}, m0.readdata, '0);
    chk({t, "_rd1"}, m1.readdata, '0);
    chk({t, "_cs"}, mem_chipselect, 1'b0);
    chk({t, "_we"}, mem_write, 1'b0);
    chk({t, "_clken"}, mem_clken, 1'b0);
    chk({t, "_err"}, oor_err, 1'b0);
  endtask
  task automatic apply_reset();
    @(negedge clk);
    drive(IDLE, IDLE, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_rst("rst");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask
  task automatic step(input cmd_t c0, input cmd_t c1, input logic clr);
    cmd_t w;
    int win;
    logic oor, hit;
    @(negedge clk);
    chk("rv0", m0.readdatavalid, e_rv0);
    chk("rv1", m1.readdatavalid, e_rv1);
    chk("rd0", m0.readdata, e_rv0 ? e_rd : '0);
    chk("rd1", m1.readdata, e_rv1 ? e_rd : '0);
    chk("oor_err", oor_err, e_err);
    chk("clken", mem_clken, 1'b1);
    cnt0 += int'(m0.readdatavalid);
    cnt1 += int'(m1.readdatavalid);
    drive(c0, c1, clr);
    #1;
    win = -1;
    if ((c0.r | c0.w) && (c1.r | c1.w)) win = (last == 0) ? 1 : 0;
    else if (c0.r | c0.w) win = 0;
    else if (c1.r | c1.w) win = 1;
    w = (win == 1) ? c1 : c0;
    oor = win >= 0 && w.a >= DEPTH;
    hit = win >= 0 && !oor;
    chk("wait0", m0.waitrequest, win != 0);
    chk("wait1", m1.waitrequest, win != 1);
    chk("cs", mem_chipselect, hit);
    chk("we", mem_write, hit && w.w);
    if (hit) begin
      chk("addr", mem_address, w.a);
      if (w.w) begin
        chk("wdata", mem_writedata, w.d);
        chk("be", mem_byteenable, w.be);
      end
    end
    e_rv0 = win == 0 && w.r && !w.w;
    e_rv1 = win == 1 && w.r && !w.w;
    e_rd = hit ? mdl[w.a] : '0;
    if (hit && w.w)
      for (int i = 0; i < BW; i++)
        if (w.be[i]) mdl[w.a][8*i +: 8] = w.d[8*i +: 8];
    e_err = (win >= 0 && oor) ? 1'b1 : clr ? 1'b0 : e_err;
    if (win >= 0) last = win;
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] <= '0;
      mdl[i] = '0;
    end
    drive(IDLE, IDLE, 1'b0);
    model_reset();
    #1;
    chk_rst("por");
    @(negedge clk);
    reset_n = 1'b1;
    step(wrc(16, 4'hF, 32'hDEADBEEF), IDLE, 1'b0);
    step(rdc(16), IDLE, 1'b0);
    @(posedge clk);
    #1;
    chk("t1_rd", m0.readdata, 32'hDEADBEEF);
    chk("t1_rv0", m0.readdatavalid, 1'b1);
    chk("t1_rv1", m1.readdatavalid, 1'b0);
    step(IDLE, IDLE, 1'b0);
    apply_reset();
    cnt0 = 0;
    cnt1 = 0;
    repeat (6) step(rdc(1), rdc(2), 1'b0);
    step(IDLE, IDLE, 1'b0);
    chk("t2_cnt0", cnt0, 3);
    chk("t2_cnt1", cnt1, 3);
    step(wrc(0, 4'hF, 32'h0), IDLE, 1'b0);
    step(IDLE, wrc(0, 4'h5, 32'h11223344), 1'b0);
    step(rdc(0), IDLE, 1'b0);
    @(posedge clk);
    #1;
    chk("t3_rd", m0.readdata, 32'h00220044);
    step(rdc(DEPTH), IDLE, 1'b0);
    @(posedge clk);
    #1;
    chk("t4_rd", m0.readdata, '0);
    chk("t4_rv", m0.readdatavalid, 1'b1);
    chk("t4_err", oor_err, 1'b1);
    n = ram_wr;
    step(IDLE, wrc(32'h7FFF, 4'hF, 32'hCAFEF00D), 1'b0);
    step(IDLE, IDLE, 1'b0);
    chk("t4_nowr", ram_wr, n);
    step(IDLE, IDLE, 1'b1);
    @(posedge clk);
    #1;
    chk("t4_clr", oor_err, 1'b0);
    step(IDLE, IDLE, 1'b0);
    @(negedge clk);
    drive(IDLE, rdc(3), 1'b0);
    #1;
    chk("t5_gnt", m1.waitrequest, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_rst("t5");
    @(posedge clk);
    #1;
    chk("t5_rv1", m1.readdatavalid, 1'b0);
    @(negedge clk);
    drive(IDLE, IDLE, 1'b0);
    reset_n = 1'b1;
    model_reset();
    step(rdc(4), rdc(5), 1'b0);
    step(IDLE, IDLE, 1'b0);
    n = ram_wr;
    for (int i = 0; i < 4; i++) step(IDLE, wrc(8 + i, 4'hF, $urandom), 1'b0);
    step(IDLE, IDLE, 1'b0);
    chk("t6_wr", ram_wr - n, 4);
    repeat (600) step(rnd(), rnd(), ($urandom % 10) == 0);
    step(IDLE, IDLE, 1'b0);
    step(IDLE, IDLE, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
